modexp_sched: RTL and testbench

MODEXP_SCHED -- requirements
Module: modexp_sched

---
 rtl/modexp_sched.sv | 203 ++++++++++++++++++++
 tb/tb_modexp_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_sched.sv
// Modular exponentiation scheduler: right-to-left square-and-multiply that
// drives an external square unit and an external mulmod unit, overlapping
// both units within each round of the exponent scan.
module modexp_sched #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic [WIDTH-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    input  logic [WIDTH-1:0]     modulus_in,
    output logic [WIDTH-1:0]     result_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 err_out,
    output logic                 sq_ready_out,
    output logic [WIDTH-1:0]     sq_value_out,
    input  logic                 sq_valid_in,
    input  logic [WIDTH-1:0]     sq_result_in,
    output logic                 mul_ready_out,
    output logic [WIDTH-1:0]     mul_a_out,
    output logic [WIDTH-1:0]     mul_b_out,
    input  logic                 mul_valid_in,
    input  logic [WIDTH-1:0]     mul_result_in,
    output logic [WIDTH-1:0]     mod_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [WIDTH-1:0]     sq_val_q, sq_val_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 err_q, err_d;
    logic                 issued_q, issued_d;
    logic                 mul_pend_q, mul_pend_d;
    logic                 sq_pend_q, sq_pend_d;

    // Shared decision terms for the FSM and the datapath.
    logic start_go, reduce_done, round_done, e_zero, sq_needed;
    assign start_go    = ready_in && (state_q == S_IDLE);
    assign reduce_done = issued_q && mul_valid_in;
    assign round_done  = (!mul_pend_q || mul_valid_in) && (!sq_pend_q || sq_valid_in);
    assign e_zero      = (e_q == '0);
    assign sq_needed   = ((e_q >> 1) != '0);

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: sequential state always uses non-blocking (<=) so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_go) state_d = (modulus_in == '0) ? S_DONE : S_REDUCE;
            S_REDUCE: if (reduce_done) state_d = S_ISSUE;
            S_ISSUE:  state_d = e_zero ? S_DONE : S_WAIT;
            S_WAIT:   if (round_done) state_d = S_ISSUE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: unit pulses and status flags follow the current state.
    always_comb begin
        mul_ready_out = ((state_q == S_REDUCE) && !issued_q) ||
                        ((state_q == S_ISSUE) && e_q[0]);
        sq_ready_out  = (state_q == S_ISSUE) && sq_needed;
        busy_out      = (state_q == S_REDUCE) || (state_q == S_ISSUE) || (state_q == S_WAIT);
        valid_out     = (state_q == S_DONE);
    end

    assign result_out   = result_q;
    assign err_out      = err_q;
    assign mod_out      = mod_q;
    assign mul_a_out    = mul_a_q;
    assign mul_b_out    = mul_b_q;
    assign sq_value_out = sq_val_q;

    // Datapath next values: operand latches are loaded on entry to the issue
    // point so they are stable from the ready pulse until the unit answers.
    always_comb begin
        acc_d      = acc_q;
        b_d        = b_q;
        e_d        = e_q;
        mod_d      = mod_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        sq_val_d   = sq_val_q;
        result_d   = result_q;
        err_d      = err_q;
        issued_d   = issued_q;
        mul_pend_d = mul_pend_q;
        sq_pend_d  = sq_pend_q;
        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    mod_d    = modulus_in;
                    e_d      = exponent_in;
                    mul_a_d  = base_in;
                    mul_b_d  = WIDTH'(1);
                    issued_d = 1'b0;
                    if (modulus_in == '0) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            S_REDUCE: begin
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (mul_valid_in) begin
                    b_d      = mul_result_in;
                    // 1 mod 1 is 0, which matters when the exponent is 0.
                    acc_d    = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    mul_a_d  = acc_d;
                    mul_b_d  = b_d;
                    sq_val_d = b_d;
                end
            end
            S_ISSUE: begin
                mul_pend_d = e_q[0];
                sq_pend_d  = sq_needed;
                if (e_zero) begin
                    result_d = acc_q;
                    err_d    = 1'b0;
                end
            end
            S_WAIT: begin
                if (mul_pend_q && mul_valid_in) begin
                    acc_d      = mul_result_in;
                    mul_pend_d = 1'b0;
                end
                if (sq_pend_q && sq_valid_in) begin
                    b_d       = sq_result_in;
                    sq_pend_d = 1'b0;
                end
                if (round_done) begin
                    e_d      = e_q >> 1;
                    mul_a_d  = acc_d;
                    mul_b_d  = b_d;
                    sq_val_d = b_d;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, all cleared by reset so every output reads 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_q      <= '0;
            b_q        <= '0;
            e_q        <= '0;
            mod_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            sq_val_q   <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            issued_q   <= 1'b0;
            mul_pend_q <= 1'b0;
            sq_pend_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            b_q        <= b_d;
            e_q        <= e_d;
            mod_q      <= mod_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            sq_val_q   <= sq_val_d;
            result_q   <= result_d;
            err_q      <= err_d;
            issued_q   <= issued_d;
            mul_pend_q <= mul_pend_d;
            sq_pend_q  <= sq_pend_d;
        end
    end

endmodule

// File: tb/tb_modexp_sched.sv
// Self-checking bench for modexp_sched: behavioural unit models with random
// latency, a plain-arithmetic reference for results and operation counts,
// and one monitor that checks every completion and the result hold.
module tb_modexp_sched;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ready_in;
    logic [15:0] base_in, modulus_in, exponent_in;
    logic [15:0] result_out, sq_value_out, sq_result_in;
    logic [15:0] mul_a_out, mul_b_out, mul_result_in, mod_out;
    logic        busy_out, valid_out, err_out;
    logic        sq_ready_out, sq_valid_in, mul_ready_out, mul_valid_in;

    modexp_sched #(.WIDTH(16), .EXP_WIDTH(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready_in),
        .base_in(base_in), .exponent_in(exponent_in), .modulus_in(modulus_in),
        .result_out(result_out), .busy_out(busy_out), .valid_out(valid_out), .err_out(err_out),
        .sq_ready_out(sq_ready_out), .sq_value_out(sq_value_out),
        .sq_valid_in(sq_valid_in), .sq_result_in(sq_result_in),
        .mul_ready_out(mul_ready_out), .mul_a_out(mul_a_out), .mul_b_out(mul_b_out),
        .mul_valid_in(mul_valid_in), .mul_result_in(mul_result_in),
        .mod_out(mod_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          muls;
        int          sqs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   fixed_lat = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: naive repeated multiplication, op counts from exponent bits.
    function automatic exp_t model(input int unsigned b, input int unsigned e, input int unsigned m);
        exp_t        x;
        longint      r;
        logic [15:0] ev;
        ev = e[15:0];
        if (m == 0) begin
            x.res = '0; x.err = 1'b1; x.muls = 0; x.sqs = 0;
            return x;
        end
        r = 1 % m;
        for (int unsigned i = 0; i < e; i++) r = (r * b) % m;
        x.res  = r[15:0];
        x.err  = 1'b0;
        x.muls = 1 + $countones(ev);
        x.sqs  = 0;
        for (int i = 15; i > 0; i--) begin
            if (ev[i]) begin
                x.sqs = i;
                break;
            end
        end
        return x;
    endfunction

    function automatic int pick_lat();
        return (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 20));
    endfunction

    // Unit models: one outstanding op each, result after 1..20 cycles.
    bit          mul_pend = 0, sq_pend = 0, mul_moved = 0, sq_moved = 0;
    int          mul_lat, sq_lat;
    logic [15:0] ma, mb, sv, mres, sres;
    initial begin
        mul_valid_in = 0; sq_valid_in = 0; mul_result_in = '0; sq_result_in = '0;
        forever begin
            @(negedge clk_in);
            mul_valid_in = 0;
            sq_valid_in  = 0;
            if (mul_pend) begin
                if (rst_in && busy_out && (mul_a_out !== ma || mul_b_out !== mb)) mul_moved = 1;
                mul_lat--;
                if (mul_lat == 0) begin
                    mul_valid_in  = 1;
                    mul_result_in = mres;
                    mul_pend      = 0;
                    check("mul_operands_held", mul_moved, 0);
                end
            end
            if (sq_pend) begin
                if (rst_in && busy_out && sq_value_out !== sv) sq_moved = 1;
                sq_lat--;
                if (sq_lat == 0) begin
                    sq_valid_in  = 1;
                    sq_result_in = sres;
                    sq_pend      = 0;
                    check("sq_operand_held", sq_moved, 0);
                end
            end
            if (rst_in && mul_ready_out) begin
                check("mul_pulse_while_pending", mul_pend, 0);
                ma = mul_a_out; mb = mul_b_out; mul_moved = 0;
                mres = 16'((longint'(ma) * longint'(mb)) % longint'(mod_out));
                mul_lat = pick_lat(); mul_pend = 1;
            end
            if (rst_in && sq_ready_out) begin
                check("sq_pulse_while_pending", sq_pend, 0);
                sv = sq_value_out; sq_moved = 0;
                sres = 16'((longint'(sv) * longint'(sv)) % longint'(mod_out));
                sq_lat = pick_lat(); sq_pend = 1;
            end
        end
    end

    // Compare process: completions against the expectation queue, result hold.
    int          mul_cnt = 0, sq_cnt = 0;
    logic [16:0] last_out = '0;
    initial begin
        exp_t x;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                mul_cnt = 0; sq_cnt = 0; last_out = '0;
            end else begin
                if (mul_ready_out) mul_cnt++;
                if (sq_ready_out) sq_cnt++;
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        check("result", result_out, x.res);
                        check("err", err_out, x.err);
                        check("mul_issues", mul_cnt, x.muls);
                        check("sq_issues", sq_cnt, x.sqs);
                        check("busy_at_valid", busy_out, 0);
                        last_out = {x.err, x.res};
                    end
                    mul_cnt = 0; sq_cnt = 0;
                    done_cnt++;
                end else begin
                    check("result_hold", {err_out, result_out}, last_out);
                end
            end
        end
    end

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk_in); #1;
            n++;
        end
        if (done_cnt < target) check("timeout_waiting_valid", done_cnt, target);
    endtask

    task automatic run(input int unsigned b, input int unsigned e, input int unsigned m, input exp_t x);
        int t;
        t = done_cnt + 1;
        @(negedge clk_in); #1;
        base_in = b[15:0]; exponent_in = e[15:0]; modulus_in = m[15:0]; ready_in = 1;
        exp_q.push_back(x);
        @(negedge clk_in); #1;
        ready_in = 0;
        wait_done(t);
    endtask

    initial begin
        exp_t x;
        int   t, bad;
        rst_in = 0; ready_in = 0; base_in = '0; exponent_in = '0; modulus_in = '0;
        repeat (2) @(negedge clk_in);
        check("reset_outputs", {result_out, busy_out, valid_out, err_out, sq_ready_out, mul_ready_out,
                                sq_value_out, mul_a_out, mul_b_out, mod_out}, 0);
        #1 rst_in = 1;

        // Pin the reference model to hand-computed values.
        x = model(3, 5, 7);     check("model_3_5_7", x.res, 5);
        x = model(2, 10, 1000); check("model_2_10_1000", x.res, 24);
        x = model(20, 1, 7);    check("model_20_1_7_sqs", x.sqs, 0);

        // Directed cases with literal expectations.
        run(3, 5, 7, '{16'd5, 1'b0, 3, 2});
        run(20, 1, 7, '{16'd6, 1'b0, 2, 0});
        run(2, 10, 1000, '{16'd24, 1'b0, 3, 3});
        fixed_lat = 4;
        run(2, 10, 1000, '{16'd24, 1'b0, 3, 3});
        fixed_lat = 0;
        run(9, 0, 13, '{16'd1, 1'b0, 1, 0});
        run(9, 0, 1, '{16'd0, 1'b0, 1, 0});
        run(9, 7, 0, '{16'd0, 1'b1, 0, 0});

        // ready_in held high across a run while operands change underneath.
        t = done_cnt;
        @(negedge clk_in); #1;
        base_in = 3; exponent_in = 5; modulus_in = 7; ready_in = 1;
        exp_q.push_back('{16'd5, 1'b0, 3, 2});
        @(negedge clk_in); #1;
        base_in = 5; exponent_in = 3; modulus_in = 11;
        exp_q.push_back('{16'd4, 1'b0, 3, 1});
        wait_done(t + 1);
        @(negedge clk_in); #1;
        @(negedge clk_in); #1;
        ready_in = 0;
        wait_done(t + 2);

        // Reset in the middle of WAIT, then let the late unit valids land.
        fixed_lat = 10;
        @(negedge clk_in); #1;
        base_in = 3; exponent_in = 5; modulus_in = 7; ready_in = 1;
        exp_q.push_back('{16'd5, 1'b0, 3, 2});
        @(negedge clk_in); #1;
        ready_in = 0;
        repeat (16) @(negedge clk_in);
        #1 rst_in = 0;
        #1 check("reset_mid_wait_outputs", {result_out, busy_out, valid_out, err_out, sq_ready_out,
                 mul_ready_out, sq_value_out, mul_a_out, mul_b_out, mod_out}, 0);
        exp_q.delete();
        @(negedge clk_in); #1 rst_in = 1;
        bad = 0;
        repeat (25) begin
            @(negedge clk_in); #1;
            if (busy_out || valid_out || mul_ready_out || sq_ready_out) bad = 1;
        end
        check("idle_after_reset_with_late_valids", bad, 0);
        fixed_lat = 0;
        run(3, 5, 7, '{16'd5, 1'b0, 3, 2});

        // Randomized runs against the reference model.
        for (int i = 0; i < 25; i++) begin
            int unsigned b, e, m, r;
            r = $urandom_range(0, 9);
            m = (r == 0) ? 0 : (r == 1) ? 1 : $urandom_range(2, 65535);
            b = $urandom_range(0, 65535);
            e = (i % 2 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 65535);
            run(b, e, m, model(b, e, m));
        end

        repeat (3) @(negedge clk_in);
        check("expectations_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
